// File: rtl/mem_access_unit_if.sv
// Data-memory request/acknowledge bus between the MEM stage and data memory.
// The MEM stage is the master (drives the request), the memory is the slave.
interface mem_access_unit_if;
  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;

  modport master (
    output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    input  dm_rdata, dm_ack
  );

  modport slave (
    input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    output dm_rdata, dm_ack
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: turns one EX/MEM load or store into a single
// request/ack transaction, formats store lanes and load results, and holds
// the pipeline with mem_stall until the access has finished.
module mem_access_unit #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_r_in,
  input  logic               mem_w_in,
  input  logic [2:0]         funct3_in,
  input  logic [31:0]        alu_in,
  input  logic [31:0]        rr2_data_in,
  input  logic [4:0]         wr_addr_in,
  mem_access_unit_if.master  bus,
  output logic               mem_stall,
  output logic               ld_valid,
  output logic [31:0]        ld_data,
  output logic [4:0]         ld_wr_addr,
  output logic               misalign_err,
  output logic               bus_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t state, next_state;

  logic            dm_req_q;
  logic            dm_we_q;
  logic [3:0]      dm_be_q;
  logic [31:0]     dm_addr_q;
  logic [31:0]     dm_wdata_q;
  logic [TO_W-1:0] count;

  logic            lat_load;
  logic [1:0]      lat_size;
  logic            lat_unsigned;
  logic [1:0]      lat_off;
  logic [4:0]      lat_wr_addr;

  logic            req_any;
  logic [1:0]      size_in;
  logic            misaligned_in;
  logic [3:0]      be_in;
  logic [31:0]     wdata_in;
  logic            timeout_hit;
  logic [7:0]      lane_b;
  logic [15:0]     lane_h;
  logic [31:0]     load_fmt;

  assign bus.dm_req   = dm_req_q;
  assign bus.dm_we    = dm_we_q;
  assign bus.dm_be    = dm_be_q;
  assign bus.dm_addr  = dm_addr_q;
  assign bus.dm_wdata = dm_wdata_q;

  assign req_any     = mem_r_in | mem_w_in;
  assign timeout_hit = (count == TO_LAST);
  assign mem_stall   = ((state == IDLE) && req_any) || (state == ACCESS);

  // Decode access size, alignment and store lane formatting of the incoming request
  always_comb begin
    case (funct3_in)
      3'b000, 3'b100: size_in = SZ_BYTE;
      3'b001, 3'b101: size_in = SZ_HALF;
      default:        size_in = SZ_WORD;
    endcase

    misaligned_in = ((size_in == SZ_HALF) && alu_in[0]) ||
                    ((size_in == SZ_WORD) && (alu_in[1:0] != 2'b00));

    be_in    = 4'b1111;
    wdata_in = rr2_data_in;
    if (mem_w_in) begin
      case (size_in)
        SZ_BYTE: begin
          be_in    = 4'b0001 << alu_in[1:0];
          wdata_in = {4{rr2_data_in[7:0]}};
        end
        SZ_HALF: begin
          be_in    = alu_in[1] ? 4'b1100 : 4'b0011;
          wdata_in = {2{rr2_data_in[15:0]}};
        end
        default: begin
          be_in    = 4'b1111;
          wdata_in = rr2_data_in;
        end
      endcase
    end
  end

  // Pick the addressed lane out of the read word and extend it to 32 bits
  always_comb begin
    case (lat_off)
      2'd0:    lane_b = bus.dm_rdata[7:0];
      2'd1:    lane_b = bus.dm_rdata[15:8];
      2'd2:    lane_b = bus.dm_rdata[23:16];
      default: lane_b = bus.dm_rdata[31:24];
    endcase
    lane_h = lat_off[1] ? bus.dm_rdata[31:16] : bus.dm_rdata[15:0];

    case (lat_size)
      SZ_BYTE: load_fmt = lat_unsigned ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
      SZ_HALF: load_fmt = lat_unsigned ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: load_fmt = bus.dm_rdata;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // FSM next state: DONE always lasts one cycle so the finished instruction is not re-issued
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req_any) next_state = misaligned_in ? DONE : ACCESS;
      ACCESS:  if (bus.dm_ack || timeout_hit) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request latching, bus drive, timeout counting and result/pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dm_req_q     <= 1'b0;
      dm_we_q      <= 1'b0;
      dm_be_q      <= 4'b0;
      dm_addr_q    <= 32'b0;
      dm_wdata_q   <= 32'b0;
      count        <= '0;
      lat_load     <= 1'b0;
      lat_size     <= SZ_BYTE;
      lat_unsigned <= 1'b0;
      lat_off      <= 2'b0;
      lat_wr_addr  <= 5'b0;
      ld_valid     <= 1'b0;
      ld_data      <= 32'b0;
      ld_wr_addr   <= 5'b0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      ld_valid     <= 1'b0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      case (state)
        IDLE: begin
          if (req_any) begin
            lat_load     <= ~mem_w_in;
            lat_size     <= size_in;
            lat_unsigned <= funct3_in[2];
            lat_off      <= alu_in[1:0];
            lat_wr_addr  <= wr_addr_in;
            if (misaligned_in) begin
              misalign_err <= 1'b1;
            end else begin
              dm_req_q   <= 1'b1;
              dm_we_q    <= mem_w_in;
              dm_be_q    <= be_in;
              dm_addr_q  <= {alu_in[31:2], 2'b00};
              dm_wdata_q <= wdata_in;
              count      <= '0;
            end
          end
        end
        ACCESS: begin
          if (bus.dm_ack) begin
            dm_req_q <= 1'b0;
            if (lat_load) begin
              ld_valid   <= 1'b1;
              ld_data    <= load_fmt;
              ld_wr_addr <= lat_wr_addr;
            end
          end else if (timeout_hit) begin
            dm_req_q <= 1'b0;
            bus_err  <= 1'b1;
            ld_data  <= 32'b0;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios followed by
// randomized loads/stores against a byte-lane reference model.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_r_in, mem_w_in;
  logic [2:0]  funct3_in;
  logic [31:0] alu_in, rr2_data_in;
  logic [4:0]  wr_addr_in;
  logic        mem_stall, ld_valid, misalign_err, bus_err;
  logic [31:0] ld_data;
  logic [4:0]  ld_wr_addr;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] model_ld_data = 32'h0;

  mem_access_unit_if bus();

  mem_access_unit #(.TIMEOUT(TO), .TO_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_r_in     (mem_r_in),
    .mem_w_in     (mem_w_in),
    .funct3_in    (funct3_in),
    .alu_in       (alu_in),
    .rr2_data_in  (rr2_data_in),
    .wr_addr_in   (wr_addr_in),
    .bus          (bus.master),
    .mem_stall    (mem_stall),
    .ld_valid     (ld_valid),
    .ld_data      (ld_data),
    .ld_wr_addr   (ld_wr_addr),
    .misalign_err (misalign_err),
    .bus_err      (bus_err)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic int size_bytes(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic bit is_misaligned(input logic [2:0] f3, input logic [31:0] addr);
    int n = size_bytes(f3);
    int off = int'(addr[1:0]);
    return (n == 2 && (off % 2) != 0) || (n == 4 && off != 0);
  endfunction

  function automatic logic [31:0] exp_be(input bit store, input logic [2:0] f3, input logic [31:0] addr);
    int n = size_bytes(f3);
    int off = int'(addr[1:0]);
    if (!store || n == 4) return 32'd15;
    if (n == 1) return 32'd1 << off;
    return 32'd3 << off;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] data);
    int n = size_bytes(f3);
    if (n == 1) return (data & 32'hFF) * 32'h01010101;
    if (n == 2) return (data & 32'hFFFF) * 32'h00010001;
    return data;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata);
    int n = size_bytes(f3);
    bit sgn = (f3 == 3'd0 || f3 == 3'd1);
    logic [31:0] v = rdata >> (8 * int'(addr[1:0]));
    if (n == 1) begin
      v = v & 32'hFF;
      if (sgn && v >= 32'd128) v = v - 32'd256;
    end else if (n == 2) begin
      v = v & 32'hFFFF;
      if (sgn && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = rdata;
    end
    return v;
  endfunction

  // One complete access, started at a negedge with the DUT in IDLE.
  // n is the cycle (counted from dm_req rising) in which dm_ack is given; n > TO means no ack.
  task automatic applyStimulus(input bit r, input bit w, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] data,
                               input logic [4:0] wr, input int n, input logic [31:0] rdata);
    bit store = w;
    bit mis = is_misaligned(f3, addr);
    bit acked = (n <= TO);
    int req_cycles = acked ? n : TO;
    logic [31:0] exp_addr = addr & 32'hFFFF_FFFC;

    bus.dm_ack = 1'b0;
    mem_r_in = r; mem_w_in = w; funct3_in = f3;
    alu_in = addr; rr2_data_in = data; wr_addr_in = wr;
    #1;
    checkOutput("stall_idle_req", mem_stall, 1);
    @(posedge clk); @(negedge clk);

    if (mis) begin
      checkOutput("mis_no_req", bus.dm_req, 0);
      checkOutput("mis_err_pulse", misalign_err, 1);
      checkOutput("mis_stall_done", mem_stall, 0);
      checkOutput("mis_ld_valid", ld_valid, 0);
      mem_r_in = 1'b0; mem_w_in = 1'b0;
      @(negedge clk);
      checkOutput("mis_err_clear", misalign_err, 0);
      checkOutput("mis_no_req_after", bus.dm_req, 0);
      return;
    end

    checkOutput("dm_addr", bus.dm_addr, exp_addr);
    checkOutput("dm_we", bus.dm_we, store);
    checkOutput("dm_be", bus.dm_be, exp_be(store, f3, addr));
    if (store) checkOutput("dm_wdata", bus.dm_wdata, exp_wdata(f3, data));

    for (int k = 1; k <= req_cycles; k++) begin
      checkOutput("dm_req_held", bus.dm_req, 1);
      checkOutput("stall_access", mem_stall, 1);
      checkOutput("dm_addr_held", bus.dm_addr, exp_addr);
      if (k == n) begin
        bus.dm_ack = 1'b1;
        bus.dm_rdata = rdata;
      end
      @(posedge clk); @(negedge clk);
      bus.dm_ack = 1'b0;
      bus.dm_rdata = $urandom;
    end

    checkOutput("done_req_low", bus.dm_req, 0);
    checkOutput("done_stall_low", mem_stall, 0);
    checkOutput("done_ld_valid", ld_valid, (!store && acked) ? 1 : 0);
    checkOutput("done_bus_err", bus_err, acked ? 0 : 1);
    checkOutput("done_misalign", misalign_err, 0);
    if (!store && acked) begin
      model_ld_data = exp_load(f3, addr, rdata);
      checkOutput("ld_wr_addr", ld_wr_addr, wr);
    end else if (!acked) begin
      model_ld_data = 32'h0;
    end
    checkOutput("ld_data", ld_data, model_ld_data);
    mem_r_in = 1'b0; mem_w_in = 1'b0;

    @(negedge clk);
    checkOutput("idle_ld_valid", ld_valid, 0);
    checkOutput("idle_bus_err", bus_err, 0);
    checkOutput("idle_ld_hold", ld_data, model_ld_data);
    checkOutput("idle_req_low", bus.dm_req, 0);
  endtask

  // Idle cycles with a stray ack that must be ignored
  task automatic idleCycles(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      bus.dm_ack = 1'($urandom_range(0, 1));
      #1;
      checkOutput("gap_stall", mem_stall, 0);
      @(negedge clk);
      checkOutput("gap_ld_valid", ld_valid, 0);
      checkOutput("gap_req", bus.dm_req, 0);
    end
    bus.dm_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    mem_r_in = 1'b0; mem_w_in = 1'b0; funct3_in = 3'b0;
    alu_in = 32'h0; rr2_data_in = 32'h0; wr_addr_in = 5'h0;
    bus.dm_ack = 1'b0; bus.dm_rdata = 32'h0;
    #1;
    checkOutput("rst_dm_req", bus.dm_req, 0);
    checkOutput("rst_dm_we", bus.dm_we, 0);
    checkOutput("rst_dm_be", bus.dm_be, 0);
    checkOutput("rst_dm_addr", bus.dm_addr, 0);
    checkOutput("rst_dm_wdata", bus.dm_wdata, 0);
    checkOutput("rst_ld_valid", ld_valid, 0);
    checkOutput("rst_ld_data", ld_data, 0);
    checkOutput("rst_ld_wr_addr", ld_wr_addr, 0);
    checkOutput("rst_misalign", misalign_err, 0);
    checkOutput("rst_bus_err", bus_err, 0);
    checkOutput("rst_stall", mem_stall, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] directed scenarios");
    applyStimulus(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd1, 2, 32'h0);
    applyStimulus(1, 0, 3'b000, 32'h103, 32'h0, 5'd7, 1, 32'h80FF1234);
    checkOutput("lb_const", ld_data, 32'hFFFFFF80);
    applyStimulus(1, 0, 3'b100, 32'h103, 32'h0, 5'd3, 3, 32'h80FF1234);
    checkOutput("lbu_const", ld_data, 32'h00000080);
    applyStimulus(0, 1, 3'b001, 32'h102, 32'h0000ABCD, 5'd0, 1, 32'h0);
    applyStimulus(1, 0, 3'b001, 32'h102, 32'h0, 5'd9, 2, 32'h8001ABCD);
    checkOutput("lh_const", ld_data, 32'hFFFF8001);
    applyStimulus(1, 0, 3'b010, 32'h101, 32'h0, 5'd4, 1, 32'h0);
    applyStimulus(1, 0, 3'b010, 32'h204, 32'h0, 5'd5, TO, 32'h12345678);
    checkOutput("lw_last_cycle_ack", ld_data, 32'h12345678);
    applyStimulus(1, 0, 3'b010, 32'h200, 32'h0, 5'd6, TO + 1, 32'h0);
    checkOutput("timeout_ld_zero", ld_data, 32'h0);
    applyStimulus(1, 1, 3'b000, 32'h105, 32'h0000005A, 5'd2, 1, 32'hFFFFFFFF);
    applyStimulus(1, 0, 3'b110, 32'h208, 32'h0, 5'd8, 1, 32'hCAFEF00D);
    idleCycles(2);

    $display("[TB] reset during access");
    mem_r_in = 1'b1; funct3_in = 3'b010; alu_in = 32'h300; wr_addr_in = 5'd11;
    @(posedge clk); @(negedge clk);
    checkOutput("pre_rst_req", bus.dm_req, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_async_req", bus.dm_req, 0);
    mem_r_in = 1'b0;
    #1;
    checkOutput("rst_async_stall", mem_stall, 0);
    @(negedge clk);
    rst = 1'b0;
    model_ld_data = 32'h0;
    bus.dm_ack = 1'b1; bus.dm_rdata = 32'h55AA55AA;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stray_ack_ld_valid", ld_valid, 0);
      checkOutput("stray_ack_req", bus.dm_req, 0);
    end
    bus.dm_ack = 1'b0;
    checkOutput("rst_ld_data_cleared", ld_data, 0);

    $display("[TB] randomized accesses");
    for (int t = 0; t < 150; t++) begin
      int kind = $urandom_range(0, 2);
      applyStimulus(kind != 1, kind != 0, 3'($urandom_range(0, 7)), $urandom, $urandom,
                    5'($urandom_range(0, 31)), $urandom_range(1, TO + 2), $urandom);
      idleCycles($urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run can never hang
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] time limit exceeded");
  end

endmodule
